// File: rtl/popcnt_accum.sv
// Chunked population counter: captures one LEN-bit vector (optionally XNOR'd
// with a weight vector), sums CHUNK bits per cycle, and compares to a threshold.
module popcnt_accum #(
  parameter int LEN   = 450,
  parameter int CHUNK = 64,
  localparam int NCH  = (LEN + CHUNK - 1) / CHUNK,
  localparam int CW   = $clog2(LEN + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [LEN-1:0] in_bits,
  input  logic [LEN-1:0] in_w,
  input  logic           xnor_en,
  input  logic [CW-1:0]  thresh,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CW-1:0]  out_cnt,
  output logic           out_ge,
  output logic [1:0]     dbg_state
);

  localparam int PW  = NCH * CHUNK;
  localparam int PCW = $clog2(CHUNK + 1);
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and the producer holds data until the transfer.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_op;
  logic [CW-1:0]   r_acc;
  logic [CW-1:0]   r_thresh;
  logic [IW-1:0]   r_idx;
  logic [CW-1:0]   r_cnt;
  logic            r_ge;

  logic [LEN-1:0]  w_op;
  logic [PW-1:0]   w_op_pad;
  logic [PCW-1:0]  w_pc;
  logic [CW-1:0]   w_sum;
  logic            w_last;

  // Padding above LEN is zero, so the partial last chunk only counts real bits.
  always_comb begin
    w_op = xnor_en ? ~(in_bits ^ in_w) : in_bits;
    w_op_pad = '0;
    w_op_pad[LEN-1:0] = w_op;
  end

  // The captured operand is shifted down each cycle, so the current chunk
  // always sits in the low CHUNK bits.
  always_comb begin
    w_pc = '0;
    for (int i = 0; i < CHUNK; i++) begin
      w_pc = w_pc + PCW'(r_op[i]);
    end
  end

  assign w_sum  = r_acc + CW'(w_pc);
  assign w_last = (r_idx == IW'(NCH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_acc    <= '0;
      r_thresh <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_ge     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op     <= w_op_pad;
            r_thresh <= thresh;
            r_acc    <= '0;
            r_idx    <= '0;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc <= w_sum;
          r_op  <= r_op >> CHUNK;
          r_idx <= r_idx + IW'(1);
          if (w_last) begin
            r_cnt   <= w_sum;
            r_ge    <= (w_sum >= r_thresh);
            r_idx   <= '0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // in_ready must drop with rst_n itself, not only with the state register.
  assign in_ready  = rst_n && (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_cnt   = r_cnt;
  assign out_ge    = r_ge;
  assign dbg_state = r_state;

endmodule

// File: doc/popcnt_accum.md
POPCNT_ACCUM -- requirements
Module: popcnt_accum

Interface
REQ-001 Parameter LEN, default 450, bit width of one input vector (LEN >= 1).
REQ-002 Parameter CHUNK, default 64, bits reduced per cycle (1 <= CHUNK <= LEN).
REQ-003 Derived constant NCH = ceil(LEN/CHUNK), chunks per vector.
REQ-004 Derived constant CW = $clog2(LEN+1), count width; all-ones input SHALL never overflow.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 in_valid  input  1  in_bits/in_w/xnor_en/thresh valid.
REQ-008 in_ready  output  1  block can accept a vector.
REQ-009 in_bits  input  LEN  activation vector.
REQ-010 in_w  input  LEN  weight vector; used only when xnor_en=1.
REQ-011 xnor_en  input  1  1: count ones of ~(in_bits ^ in_w); 0: count ones of in_bits.
REQ-012 thresh  input  CW  compare threshold, captured with the vector.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 out_cnt  output  CW  popcount result.
REQ-016 out_ge  output  1  1 when out_cnt >= captured thresh (unsigned).

Function
REQ-017 States SHALL be IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-018 IDLE, in_valid=1: at that edge capture operand vector (in_bits, or ~(in_bits^in_w) if xnor_en=1) and thresh, clear accumulator, chunk index=0, go BUSY.
REQ-019 IDLE, in_valid=0: remain IDLE, no state change.
REQ-020 BUSY: each edge add popcount of captured bits [idx*CHUNK +: CHUNK] to accumulator, increment idx.
REQ-021 Last chunk: bit positions >= LEN SHALL contribute 0 (masked, never read from in_bits/in_w).
REQ-022 BUSY -> DONE on the edge that adds chunk NCH-1; out_valid first high NCH edges after the acceptance edge (8 for defaults).
REQ-023 DONE: out_cnt, out_ge held stable while out_valid=1 and out_ready=0, for any duration.
REQ-024 DONE, out_ready=1: result consumed at that edge, go IDLE; in_ready high next cycle (no same-cycle accept).
REQ-025 out_ready in IDLE/BUSY SHALL be ignored; in_valid in BUSY/DONE SHALL be ignored and not captured.
REQ-026 Input ports need only be stable in the acceptance cycle; later changes SHALL not affect the result.
REQ-027 Accumulator width CW; no intermediate wrap; per-chunk popcount width $clog2(CHUNK+1).
REQ-028 out_ge computed from final accumulator vs captured thresh; registered, valid with out_valid.
REQ-029 NCH=1 (CHUNK=LEN) SHALL work: out_valid one edge after acceptance.
REQ-030 Throughput: one vector per NCH+2 cycles with out_ready held 1.

Reset
REQ-031 rst_n=0 SHALL immediately, without clk, force state IDLE, out_valid=0, out_cnt=0, out_ge=0, accumulator=0, idx=0.
REQ-032 in_ready SHALL be 0 while rst_n=0 and 1 from first cycle after deassertion.
REQ-033 Reset during BUSY or DONE SHALL discard the in-flight vector; no out_valid pulse for it after release.
REQ-034 rst_n deassertion is synchronised externally; block assumes clean release to clk.

Verification
REQ-035 Defaults, xnor_en=0, in_bits all ones, thresh=450 -> out_valid 8 edges after accept, out_cnt=450, out_ge=1; thresh=451 -> out_ge=0.
REQ-036 in_bits=0 except bits 0, 63, 64, 448, 449 -> out_cnt=5; verifies chunk boundaries and partial last chunk.
REQ-037 xnor_en=1, in_bits=in_w=random -> out_cnt=450; in_w=~in_bits -> out_cnt=0, out_ge=1 only if thresh=0.
REQ-038 out_ready held 0 for 5 cycles in DONE, in_valid toggling -> out_cnt/out_ge stable, in_ready=0, no new capture; release -> IDLE next cycle.
REQ-039 rst_n pulsed low at BUSY chunk 4 -> outputs 0 asynchronously; new vector of 10 ones after release -> out_cnt=10, no stale result.
REQ-040 LEN=CHUNK=32, all ones -> out_valid 1 edge after accept, out_cnt=32 (CW=6); back-to-back vectors every 3 cycles.
